csa_cpa_pipe: RTL and testbench

Two-stage pipelined carry-propagate adder that sits directly downstream of the 4:2 carry-save compressor. It collapses the redundant sum/carry vector pair into one binary result, with a valid/ready handshake on both sides. Bits are split into a low segment (stage 1) and a high segment (stage 2) so that each stage's carry chain is about half the operand width. A tag travels alongside the data so the consumer can match each result to its operation.

---
 rtl/csa_cpa_pipe_pkg.sv | 20 ++
 rtl/csa_cpa_pipe_if.sv | 28 ++
 rtl/csa_cpa_pipe_cpa_seg.sv | 12 +
 rtl/csa_cpa_pipe.sv | 126 ++++++++++++
 tb/tb_csa_cpa_pipe.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/csa_cpa_pipe_pkg.sv
// Shared widths and debug view for the two-stage carry-propagate adder
// that collapses the 4:2 CSA sum/carry pair into a binary result.
package csa_cpa_pipe_pkg;

  localparam int CPA_WIDTH = 32;
  localparam int CPA_TAG_W = 4;

  // Low segment gets the floor half of the WIDTH+1-bit operand.
  function automatic int cpa_lo_w(input int width);
    return (width + 1) / 2;
  endfunction

  typedef struct packed {
    logic s1_v;
    logic s2_v;
    logic in_xfer;
    logic out_xfer;
  } pipe_dbg_t;

endpackage

// File: rtl/csa_cpa_pipe_if.sv
// Operand/result bus of the CPA pipe. Handshake: a beat transfers on a
// rising edge where valid && ready; ready never depends on valid.
interface csa_cpa_pipe_if
  import csa_cpa_pipe_pkg::*;
#(
  parameter int WIDTH = CPA_WIDTH,
  parameter int TAG_W = CPA_TAG_W
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH:0]   in_sum;
  logic [WIDTH:0]   in_carry;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH+1:0] out_result;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_sum, in_carry, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag
  );

  modport slave (
    input  in_valid, in_sum, in_carry, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag
  );
endinterface

// File: rtl/csa_cpa_pipe_cpa_seg.sv
// N-bit ripple segment with carry-in and carry-out; one per pipe stage.
module cpa_seg #(
  parameter int N = 16
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         cin_i,
  output logic [N-1:0] s_o,
  output logic         cout_o
);
  assign {cout_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{N{1'b0}}, cin_i};
endmodule

// File: rtl/csa_cpa_pipe.sv
// Two-stage CPA: stage 1 adds the low segment, stage 2 adds the high
// segment with the low carry. Outputs are driven only from stage-2 registers.
module csa_cpa_pipe
  import csa_cpa_pipe_pkg::*;
#(
  parameter int WIDTH = CPA_WIDTH,
  parameter int TAG_W = CPA_TAG_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  csa_cpa_pipe_if.slave        bus,
  output pipe_dbg_t            dbg_o
);
  localparam int LO_W = cpa_lo_w(WIDTH);
  localparam int HI_W = WIDTH + 1 - LO_W;

  logic             s1_v_q, s1_v_d;
  logic [LO_W:0]    s1_lo_q, s1_lo_d;
  logic [HI_W-1:0]  s1_hi_sum_q, s1_hi_sum_d;
  logic [HI_W-1:0]  s1_hi_carry_q, s1_hi_carry_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

  logic             s2_v_q, s2_v_d;
  logic [HI_W:0]    s2_hi_q, s2_hi_d;
  logic [LO_W-1:0]  s2_lo_q, s2_lo_d;
  logic [TAG_W-1:0] s2_tag_q, s2_tag_d;

  logic [LO_W-1:0]  lo_s;
  logic             lo_c;
  logic [HI_W-1:0]  hi_s;
  logic             hi_c;

  logic s2_free, s1_free, in_xfer, out_xfer, s1_adv;

  cpa_seg #(.N(LO_W)) u_lo (
    .a_i   (bus.in_sum[LO_W-1:0]),
    .b_i   (bus.in_carry[LO_W-1:0]),
    .cin_i (1'b0),
    .s_o   (lo_s),
    .cout_o(lo_c)
  );

  cpa_seg #(.N(HI_W)) u_hi (
    .a_i   (s1_hi_sum_q),
    .b_i   (s1_hi_carry_q),
    .cin_i (s1_lo_q[LO_W]),
    .s_o   (hi_s),
    .cout_o(hi_c)
  );

  assign s2_free  = !s2_v_q || bus.out_ready;
  assign s1_free  = !s1_v_q || s2_free;
  assign in_xfer  = bus.in_valid && s1_free;
  assign out_xfer = s2_v_q && bus.out_ready;
  assign s1_adv   = s1_v_q && s2_free;

  always_comb begin
    s1_v_d        = s1_v_q;
    s1_lo_d       = s1_lo_q;
    s1_hi_sum_d   = s1_hi_sum_q;
    s1_hi_carry_d = s1_hi_carry_q;
    s1_tag_d      = s1_tag_q;
    s2_v_d        = s2_v_q;
    s2_hi_d       = s2_hi_q;
    s2_lo_d       = s2_lo_q;
    s2_tag_d      = s2_tag_q;

    if (in_xfer) begin
      s1_v_d        = 1'b1;
      s1_lo_d       = {lo_c, lo_s};
      s1_hi_sum_d   = bus.in_sum[WIDTH:LO_W];
      s1_hi_carry_d = bus.in_carry[WIDTH:LO_W];
      s1_tag_d      = bus.in_tag;
    end else if (s1_adv) begin
      s1_v_d = 1'b0;
    end

    if (s1_adv) begin
      s2_v_d   = 1'b1;
      s2_hi_d  = {hi_c, hi_s};
      s2_lo_d  = s1_lo_q[LO_W-1:0];
      s2_tag_d = s1_tag_q;
    end else if (out_xfer) begin
      s2_v_d = 1'b0;
    end

    // Flush only kills the valid flags; data is don't-care once invalid.
    if (flush) begin
      s1_v_d = 1'b0;
      s2_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_q        <= 1'b0;
      s1_lo_q       <= '0;
      s1_hi_sum_q   <= '0;
      s1_hi_carry_q <= '0;
      s1_tag_q      <= '0;
      s2_v_q        <= 1'b0;
      s2_hi_q       <= '0;
      s2_lo_q       <= '0;
      s2_tag_q      <= '0;
    end else begin
      s1_v_q        <= s1_v_d;
      s1_lo_q       <= s1_lo_d;
      s1_hi_sum_q   <= s1_hi_sum_d;
      s1_hi_carry_q <= s1_hi_carry_d;
      s1_tag_q      <= s1_tag_d;
      s2_v_q        <= s2_v_d;
      s2_hi_q       <= s2_hi_d;
      s2_lo_q       <= s2_lo_d;
      s2_tag_q      <= s2_tag_d;
    end
  end

  assign bus.in_ready   = s1_free;
  assign bus.out_valid  = s2_v_q;
  assign bus.out_result = {s2_hi_q, s2_lo_q};
  assign bus.out_tag    = s2_tag_q;

  assign dbg_o = '{s1_v: s1_v_q, s2_v: s2_v_q, in_xfer: in_xfer, out_xfer: out_xfer};

endmodule

// File: tb/tb_csa_cpa_pipe.sv
// Directed bench for csa_cpa_pipe: hand-computed sums plus an in-order
// scoreboard of {tag, result} for every accepted operation.
module tb_csa_cpa_pipe;
  import csa_cpa_pipe_pkg::*;

  localparam int WIDTH = CPA_WIDTH;
  localparam int TAG_W = CPA_TAG_W;

  logic      clk;
  logic      rst;
  logic      flush;
  pipe_dbg_t dbg;

  csa_cpa_pipe_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

  csa_cpa_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk  (clk),
    .rst  (rst),
    .flush(flush),
    .bus  (bus),
    .dbg_o(dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n_in  = 0;
  int n_out = 0;
  logic [TAG_W+WIDTH+1:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes at negedge, update scoreboard, return #1 after posedge.
  task automatic cycle(output bit hs);
    logic [TAG_W+WIDTH+1:0] e;
    logic [WIDTH+1:0]       r;
    @(negedge clk);
    hs = bus.in_valid && bus.in_ready;
    if (rst || flush) begin
      exp_q.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        chk("q_nonempty", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("sb_result", 64'(bus.out_result), 64'(e[WIDTH+1:0]));
          chk("sb_tag", 64'(bus.out_tag), 64'(e[TAG_W+WIDTH+1:WIDTH+2]));
        end
        n_out++;
      end
      if (hs) begin
        r = (WIDTH+2)'(bus.in_sum) + (WIDTH+2)'(bus.in_carry);
        exp_q.push_back({bus.in_tag, r});
        n_in++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    bit hs;
    cycle(hs);
  endtask

  task automatic drive_rand();
    bus.in_sum   = (WIDTH+1)'({$urandom(), $urandom()});
    bus.in_carry = (WIDTH+1)'({$urandom(), $urandom()});
    bus.in_tag   = TAG_W'($urandom_range(15, 0));
  endtask

  // Single op into an empty pipe; checks two-edge latency against a hand value.
  task automatic send_one(input logic [WIDTH:0] s, input logic [WIDTH:0] c,
                          input logic [TAG_W-1:0] t, input logic [WIDTH+1:0] exp_r,
                          input string name);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_sum    = s;
    bus.in_carry  = c;
    bus.in_tag    = t;
    #1;
    chk({name, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    step();
    bus.in_valid = 1'b0;
    chk({name, "_lat1_valid"}, 64'(bus.out_valid), 64'd0);
    step();
    chk({name, "_valid"}, 64'(bus.out_valid), 64'd1);
    chk({name, "_result"}, 64'(bus.out_result), 64'(exp_r));
    chk({name, "_tag"}, 64'(bus.out_tag), 64'(t));
    step();
    chk({name, "_drained"}, 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    bit               hs;
    logic [WIDTH+1:0] held_r;
    logic [TAG_W-1:0] held_t;

    rst           = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_sum    = '0;
    bus.in_carry  = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_result", 64'(bus.out_result), 64'd0);
    chk("rst_out_tag", 64'(bus.out_tag), 64'd0);
    rst = 1'b0;
    step();

    send_one(33'h0_0000_0003, 33'h0_0000_0004, 4'h5, 34'h0_0000_0007, "small");
    send_one(33'h1_FFFF_FFFF, 33'h0_0000_0001, 4'hA, 34'h2_0000_0000, "xseg");
    send_one(33'h1_FFFF_FFFF, 33'h1_FFFF_FFFF, 4'hF, 34'h3_FFFF_FFFE, "max");

    // back-to-back burst: out_valid must be high from the 2nd edge to the 9th
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive_rand();
      #1;
      chk("burst_in_ready", 64'(bus.in_ready), 64'd1);
      chk("burst_out_valid", 64'(bus.out_valid), 64'(i >= 2));
      step();
    end
    bus.in_valid = 1'b0;
    for (int j = 8; j < 11; j++) begin
      chk("burst_tail_valid", 64'(bus.out_valid), 64'(j < 10));
      step();
    end
    chk("burst_all_out", 64'(exp_q.size()), 64'd0);

    // stall: out_ready low, in_valid held; two accepts then backpressure
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    drive_rand();
    held_r = '0;
    held_t = '0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("stall_in_ready", 64'(bus.in_ready), 64'(k < 2));
      if (k == 2) begin
        chk("stall_out_valid", 64'(bus.out_valid), 64'd1);
        held_r = bus.out_result;
        held_t = bus.out_tag;
      end
      if (k > 2) begin
        chk("stall_result_stable", 64'(bus.out_result), 64'(held_r));
        chk("stall_tag_stable", 64'(bus.out_tag), 64'(held_t));
      end
      cycle(hs);
      if (hs) drive_rand();
    end
    bus.out_ready = 1'b1;
    #1;
    chk("release_in_ready", 64'(bus.in_ready), 64'd1);
    for (int k = 0; k < 4; k++) begin
      cycle(hs);
      chk("release_accept", 64'(hs), 64'd1);
      if (hs) drive_rand();
    end
    bus.in_valid = 1'b0;
    repeat (3) step();
    chk("release_drained", 64'(exp_q.size()), 64'd0);
    chk("release_count", 64'(n_out), 64'(n_in));

    // flush with two ops in flight; the concurrent input is discarded
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    drive_rand();
    step();
    drive_rand();
    step();
    drive_rand();
    flush = 1'b1;
    #1;
    chk("flush_in_ready_full", 64'(bus.in_ready), 64'd0);
    step();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
    chk("flush_in_ready", 64'(bus.in_ready), 64'd1);
    step();
    chk("flush_no_ghost", 64'(bus.out_valid), 64'd0);
    send_one(33'h0_0000_FFFF, 33'h0_0001_0001, 4'h3, 34'h0_0002_0000, "post_flush");

    // asynchronous reset mid-burst
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_rand();
      step();
    end
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("arst_out_result", 64'(bus.out_result), 64'd0);
    step();
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("post_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
    step();
    send_one(33'h0_1234_5678, 33'h0_0FED_CBA9, 4'h9, 34'h0_2222_2221, "post_rst");

    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
